// File: rtl/pe_load_sequencer.sv
// Load -> compute -> drain sequencer for a single PE: streams kernel and activation
// tile from the GLB into the PE, then runs one compute per output row and drains psums.
module pe_load_sequencer #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int GLB_ADDR_BITWIDTH = 10,
    parameter int KERNEL_SIZE       = 3,
    parameter int ACT_SIZE          = 5,
    parameter int W_BASE            = 0,
    parameter int A_BASE            = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic                         glb_rd_en,
    output logic [GLB_ADDR_BITWIDTH-1:0] glb_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]     glb_rd_data,
    output logic [DATA_BITWIDTH-1:0]     filt_out,
    output logic [DATA_BITWIDTH-1:0]     act_out,
    output logic                         load_en_wght,
    output logic                         load_en_act,
    output logic                         pe_start,
    input  logic                         pe_load_done,
    input  logic                         pe_compute_done,
    input  logic [DATA_BITWIDTH-1:0]     pe_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DATA_BITWIDTH-1:0]     res_data,
    output logic [2:0]                   res_idx,
    output logic                         busy,
    output logic                         done
);
    localparam int W_COUNT   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int A_COUNT   = ACT_SIZE * ACT_SIZE;
    localparam int NUM_ROWS  = ACT_SIZE - KERNEL_SIZE + 1;
    localparam int MAX_COUNT = (A_COUNT > W_COUNT) ? A_COUNT : W_COUNT;
    localparam int CNT_BITS  = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_BITS-1:0] W_LAST   = CNT_BITS'(W_COUNT - 1);
    localparam logic [CNT_BITS-1:0] A_LAST   = CNT_BITS'(A_COUNT - 1);
    localparam logic [2:0]          ROW_LAST = 3'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W_FETCH, S_W_WAIT, S_A_FETCH, S_A_WAIT, S_RUN, S_CWAIT, S_DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;
    logic [2:0]               row_q, row_d;
    logic                     load_done_q, compute_done_q;
    logic                     rd_vld_q, rd_first_q, rd_act_q;
    logic                     rd_first_d, rd_act_d;
    logic [DATA_BITWIDTH-1:0] filt_q, filt_d, act_q, act_d;
    logic                     load_en_wght_q, load_en_wght_d, load_en_act_q, load_en_act_d;
    logic                     pe_start_q, pe_start_d;
    logic                     res_valid_q, res_valid_d;
    logic [DATA_BITWIDTH-1:0] res_data_q, res_data_d;
    logic [2:0]               res_idx_q, res_idx_d;
    logic                     done_q, done_d;
    logic                     load_rise, compute_rise;

    // Only a 0->1 transition of the PE status levels advances the sequence.
    assign load_rise    = pe_load_done & ~load_done_q;
    assign compute_rise = pe_compute_done & ~compute_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        glb_rd_en   = 1'b0;
        glb_rd_addr = '0;
        rd_first_d  = 1'b0;
        rd_act_d    = 1'b0;
        pe_start_d  = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_W_FETCH;
                    cnt_d   = '0;
                end
            end
            S_W_FETCH: begin
                glb_rd_en   = 1'b1;
                glb_rd_addr = GLB_ADDR_BITWIDTH'(W_BASE) + GLB_ADDR_BITWIDTH'(cnt_q);
                rd_first_d  = (cnt_q == '0);
                if (cnt_q == W_LAST) begin
                    state_d = S_W_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_W_WAIT: begin
                if (load_rise) begin
                    state_d = S_A_FETCH;
                    cnt_d   = '0;
                end
            end
            S_A_FETCH: begin
                glb_rd_en   = 1'b1;
                glb_rd_addr = GLB_ADDR_BITWIDTH'(A_BASE) + GLB_ADDR_BITWIDTH'(cnt_q);
                rd_first_d  = (cnt_q == '0);
                rd_act_d    = 1'b1;
                if (cnt_q == A_LAST) begin
                    state_d = S_A_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_A_WAIT: begin
                if (load_rise) begin
                    row_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                pe_start_d = 1'b1;
                state_d    = S_CWAIT;
            end
            S_CWAIT: begin
                if (compute_rise) begin
                    res_data_d  = pe_out;
                    res_idx_d   = row_q;
                    res_valid_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (row_q == ROW_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d   = row_q + 3'd1;
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read return path: data is on glb_rd_data the cycle after the request and is
    // registered onto the PE bus one cycle later, together with the first-element pulse.
    always_comb begin
        filt_d         = filt_q;
        act_d          = act_q;
        load_en_wght_d = rd_vld_q & rd_first_q & ~rd_act_q;
        load_en_act_d  = rd_vld_q & rd_first_q & rd_act_q;
        if (rd_vld_q) begin
            if (rd_act_q) begin
                act_d = glb_rd_data;
            end else begin
                filt_d = glb_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            row_q          <= '0;
            load_done_q    <= 1'b0;
            compute_done_q <= 1'b0;
            rd_vld_q       <= 1'b0;
            rd_first_q     <= 1'b0;
            rd_act_q       <= 1'b0;
            filt_q         <= '0;
            act_q          <= '0;
            load_en_wght_q <= 1'b0;
            load_en_act_q  <= 1'b0;
            pe_start_q     <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_idx_q      <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            row_q          <= row_d;
            load_done_q    <= pe_load_done;
            compute_done_q <= pe_compute_done;
            rd_vld_q       <= glb_rd_en;
            rd_first_q     <= rd_first_d;
            rd_act_q       <= rd_act_d;
            filt_q         <= filt_d;
            act_q          <= act_d;
            load_en_wght_q <= load_en_wght_d;
            load_en_act_q  <= load_en_act_d;
            pe_start_q     <= pe_start_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            res_idx_q      <= res_idx_d;
            done_q         <= done_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign filt_out     = filt_q;
    assign act_out      = act_q;
    assign load_en_wght = load_en_wght_q;
    assign load_en_act  = load_en_act_q;
    assign pe_start     = pe_start_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_idx      = res_idx_q;
    assign done         = done_q;

endmodule

// File: doc/pe_load_sequencer.md
# pe_load_sequencer

Control stage directly upstream of a single PE. On a command it fetches the PE's kernel and activation tile from the global buffer (GLB) and streams them into the PE's scratchpad-load ports. It then drives one `start` pulse per output row, waits for each `compute_done`, and forwards each captured partial sum downstream over a valid/ready result port. It owns the whole load → compute → drain sequence for one PE, so the array controller deals only in commands and results.

## Interface
- DATA_BITWIDTH, 16, width of GLB data, weights, activations and psums
- GLB_ADDR_BITWIDTH, 10, GLB address width
- KERNEL_SIZE, 3, kernel side; KERNEL_SIZE² weights per load
- ACT_SIZE, 5, activation tile side; ACT_SIZE² activations per load
- W_BASE, 0, GLB address of weight 0
- A_BASE, 16, GLB address of activation 0

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  start a sequence
- cmd_ready  out  1  high only in IDLE
- glb_rd_en  out  1  GLB read request
- glb_rd_addr  out  GLB_ADDR_BITWIDTH  GLB read address
- glb_rd_data  in  DATA_BITWIDTH  GLB data, valid 1 cycle after glb_rd_en
- filt_out  out  DATA_BITWIDTH  weight stream to PE filt_in
- act_out  out  DATA_BITWIDTH  activation stream to PE act_in
- load_en_wght  out  1  1-cycle pulse aligned with weight 0
- load_en_act  out  1  1-cycle pulse aligned with activation 0
- pe_start  out  1  1-cycle compute start pulse
- pe_load_done  in  1  PE load-complete level
- pe_compute_done  in  1  PE row-complete level
- pe_out  in  DATA_BITWIDTH  PE psum
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_data  out  DATA_BITWIDTH  captured psum
- res_idx  out  3  row index 0..R-1, where R = ACT_SIZE−KERNEL_SIZE+1
- busy  out  1  high whenever not IDLE
- done  out  1  1-cycle pulse at end of sequence

## Operation
States and transitions:
- IDLE: the handshake cmd_valid & cmd_ready moves the FSM to W_FETCH.
- W_FETCH: issues KERNEL_SIZE² consecutive reads, addresses W_BASE + 0 … W_BASE + K²−1, then goes to W_WAIT.
- W_WAIT: on a rising edge of pe_load_done, goes to A_FETCH.
- A_FETCH: issues ACT_SIZE² consecutive reads from A_BASE, then goes to A_WAIT.
- A_WAIT: on a rising edge of pe_load_done, sets row = 0 and goes to RUN.
- RUN: pulses pe_start for exactly 1 cycle, then goes to CWAIT.
- CWAIT: on a rising edge of pe_compute_done, captures pe_out → res_data and row → res_idx, then goes to DRAIN.
- DRAIN: holds res_valid until res_ready. On acceptance:
  - if row == R−1, goes to IDLE and pulses done;
  - otherwise increments row and goes to RUN.

Rules:
- Edge detection uses a registered copy of pe_load_done and pe_compute_done; only a 0→1 transition counts.
- The read pipeline registers glb_rd_data into filt_out/act_out every cycle data returns. Each load_en pulse is registered and coincides with element 0 on the bus. Elements arrive on consecutive cycles with no gaps.
- filt_out and act_out hold their last value between streams.
- Only R start pulses are issued per command; the block never pulses pe_start while res_valid is high.
- cmd_valid outside IDLE is ignored; nothing is queued.
- The row counter is sized to 3 bits; R ≤ 8 is required.

## Timing
- Reset value of every output: 0, except cmd_ready = 1 (IDLE). The row counter and edge registers also reset to 0.
- reset mid-sequence: state returns to IDLE on the next edge and any pending result is dropped. The PE must be reset together with this block.
- Cycle 0 is the handshake cycle:
  - cycle 1: first glb_rd_en;
  - reads occupy cycles 1…K²;
  - load_en_wght and weight 0 appear at cycle 3;
  - weight k appears at cycle 3+k.
- The activation stream follows the same offsets relative to the first A_FETCH cycle: load_en_act with activation 0 two cycles after the first activation read.
- pe_start appears 1 cycle after entering RUN. res_valid rises the cycle after the compute_done edge is detected.
- When res_valid & res_ready are both high in the same cycle, the next pe_start occurs 2 cycles later, or done pulses 1 cycle later.
- A res_ready stall of any length holds res_data and res_idx stable.
- done and cmd_ready both rise on the same cycle after the final acceptance.

## Test plan
- Bench setup: PE instance plus a GLB model, with weights 1..9 at W_BASE and activations all 1 at A_BASE; one command with res_ready tied high. Required response: results 6, 6, 6 with res_idx 0, 1, 2, then a single done pulse.
- Activations = index 0..24. Required response: results 8, 38, 68 in row order.
- Stream alignment check:
  - load_en_wght is high exactly 1 cycle, with filt_out = 1 on that cycle;
  - filt_out equals 9 at 8 cycles later;
  - glb_rd_en is high for exactly 9 contiguous cycles, then exactly 25 in the activation phase.
- Hold res_ready low 5 cycles on row 1. Required response: res_data and res_idx stay stable, no pe_start is issued, and row 2 proceeds after acceptance.
- Pulse cmd_valid during CWAIT. Required response: ignored, cmd_ready = 0, exactly 3 results.
- Assert reset during A_FETCH. Required response: all outputs 0 and cmd_ready = 1 next cycle; a new command then completes with correct results.
